// File: rtl/alu_seq_pkg.sv
// alu_seq shared types: opcodes, flag bit positions, FSM states.
// ALU_MUL_EN adds the MUL state to the state enum.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_CMP  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_ROL  = 4'd9,
        OP_ROR  = 4'd10,
        OP_PASS = 4'd11,
        OP_MUL  = 4'd12
    } op_e;

    localparam int F_C   = 0;
    localparam int F_Z   = 1;
    localparam int F_N   = 2;
    localparam int F_V   = 3;
    localparam int F_S   = 4;
    localparam int F_EQ  = 5;
    localparam int F_RSV = 6;
    localparam int F_ILL = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef ALU_MUL_EN
        ST_MUL   = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic is_shift(logic [3:0] op);
        return (op >= OP_SLL) && (op <= OP_ROR);
    endfunction

    // Arithmetic-style flag update; EQ is held, ILL cleared.
    function automatic logic [7:0] upd_flags(
        logic [7:0] f,
        logic       c,
        logic       v,
        logic       z,
        logic       n
    );
        logic [7:0] r;
        r        = f;
        r[F_C]   = c;
        r[F_V]   = v;
        r[F_Z]   = z;
        r[F_N]   = n;
        r[F_S]   = n ^ v;
        r[F_RSV] = 1'b0;
        r[F_ILL] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_seq single-cycle datapath: next result/flags for
// ADD, SUB, AND, OR, XOR, CMP, PASS and illegal opcodes.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       flags_in,
    output logic [WIDTH-1:0] res_nxt,
    output logic [7:0]       flags_nxt,
    output logic             res_we
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] lres;
    logic             add_v;
    logic             sub_v;

    // Shared adder/subtractor; diff[WIDTH] is the unsigned borrow.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        add_v = (a[M] == b[M]) && (sum[M] != a[M]);
        sub_v = (a[M] != b[M]) && (diff[M] != a[M]);
    end

    // Opcode decode into next result, flags and result write enable.
    always_comb begin
        res_nxt   = '0;
        flags_nxt = flags_in;
        res_we    = 1'b1;
        lres      = '0;
        unique case (op)
            OP_ADD: begin
                res_nxt   = sum[M:0];
                flags_nxt = upd_flags(flags_in, sum[WIDTH], add_v,
                                      sum[M:0] == '0, sum[M]);
            end
            OP_SUB, OP_CMP: begin
                res_nxt   = diff[M:0];
                res_we    = (op == OP_SUB);
                flags_nxt = upd_flags(flags_in, diff[WIDTH], sub_v,
                                      diff[M:0] == '0, diff[M]);
                if (op == OP_CMP) begin
                    flags_nxt[F_EQ] = (a == b);
                end
            end
            OP_AND, OP_OR, OP_XOR, OP_PASS: begin
                case (op)
                    OP_AND:  lres = a & b;
                    OP_OR:   lres = a | b;
                    OP_XOR:  lres = a ^ b;
                    default: lres = b;
                endcase
                res_nxt   = lres;
                flags_nxt = upd_flags(flags_in, 1'b0, 1'b0,
                                      lres == '0, lres[M]);
            end
            default: begin
                res_nxt          = '0;
                flags_nxt[F_RSV] = 1'b0;
                flags_nxt[F_ILL] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative shifts/rotates.
// Define ALU_MUL_EN to enable the iterative MUL (op 12).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [7:0]         flags,
    output logic               busy
);

    localparam int M = WIDTH - 1;

    state_e             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         sh_op;
    logic [WIDTH-1:0]   sh_nxt;
    logic               sh_bit;
    logic [WIDTH-1:0]   core_res;
    logic [7:0]         core_flags;
    logic               core_we;
    logic               accept;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               mul_hi;
`endif

    assign in_ready = (state == ST_IDLE) ||
                      (state == ST_DONE && out_ready);
    assign accept   = in_valid && in_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op        (op),
        .a         (a),
        .b         (b),
        .flags_in  (flags),
        .res_nxt   (core_res),
        .flags_nxt (core_flags),
        .res_we    (core_we)
    );

    // One-bit shift/rotate step of the working register.
    always_comb begin
        sh_nxt = work;
        sh_bit = 1'b0;
        case (sh_op)
            OP_SLL: begin
                sh_nxt = {work[M-1:0], 1'b0};
                sh_bit = work[M];
            end
            OP_SRL: begin
                sh_nxt = {1'b0, work[M:1]};
                sh_bit = work[0];
            end
            OP_SRA: begin
                sh_nxt = {work[M], work[M:1]};
                sh_bit = work[0];
            end
            OP_ROL: begin
                sh_nxt = {work[M-1:0], work[M]};
                sh_bit = work[M];
            end
            default: begin
                sh_nxt = {work[0], work[M:1]};
                sh_bit = work[0];
            end
        endcase
    end

`ifdef ALU_MUL_EN
    // Shift-add step: add the shifted multiplicand for each set b bit.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
        mul_hi  = |acc_nxt[2*WIDTH-1:WIDTH];
    end
`endif

    // Control FSM plus result, flag and iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            work      <= '0;
            cnt       <= '0;
            sh_op     <= '0;
`ifdef ALU_MUL_EN
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
`endif
        end else if (accept) begin
            if (is_shift(op)) begin
                if (shamt == '0) begin
                    result    <= a;
                    flags     <= upd_flags(flags, 1'b0, 1'b0,
                                           a == '0, a[M]);
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    work      <= a;
                    cnt       <= shamt;
                    sh_op     <= op;
                    state     <= ST_SHIFT;
                    out_valid <= 1'b0;
                    busy      <= 1'b1;
                end
            end
`ifdef ALU_MUL_EN
            else if (op == OP_MUL) begin
                acc       <= '0;
                mcand     <= {{WIDTH{1'b0}}, a};
                mplier    <= b;
                cnt       <= SHAMT_W'(WIDTH - 1);
                state     <= ST_MUL;
                out_valid <= 1'b0;
                busy      <= 1'b1;
            end
`endif
            else begin
                if (core_we) begin
                    result <= core_res;
                end
                flags     <= core_flags;
                state     <= ST_DONE;
                out_valid <= 1'b1;
                busy      <= 1'b0;
            end
        end else begin
            case (state)
                ST_SHIFT: begin
                    work <= sh_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        result    <= sh_nxt;
                        flags     <= upd_flags(flags, sh_bit, 1'b0,
                                               sh_nxt == '0, sh_nxt[M]);
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result    <= acc_nxt[M:0];
                        flags     <= upd_flags(flags, mul_hi, mul_hi,
                                               acc_nxt[M:0] == '0,
                                               acc_nxt[M]);
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the 8-bit calc/shift ALU. Accepts one operation per valid/ready handshake, executes arithmetic/logic ops in one cycle and shifts/rotates iteratively one bit per cycle, and holds the registered result and sticky flags until the consumer takes them. Sits between the register-file read ports and the writeback/databus driver.

## Interface

Parameters:
- WIDTH, 8, datapath width; power of two, 4 to 64.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; in_ready = (state==IDLE) || (state==DONE && out_ready).
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 SLL, 7 SRL, 8 SRA, 9 ROL, 10 ROR, 11 PASS (result=b), 12 MUL (macro only); others illegal.
- a, b  in  WIDTH  operands.
- shamt  in  SHAMT_W  shift/rotate count.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- flags  out  8  registered flags: [0] C, [1] Z, [2] N, [3] V, [4] S=N^V, [5] EQ, [6] reserved 0, [7] ILL.
- busy  out  1  high in SHIFT or MUL.

## Operation

- States: IDLE, SHIFT, MUL, DONE.
- Accept on in_valid && in_ready; a, b, op and shamt are captured, and later input changes are ignored.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, CMP, PASS, illegal) go to DONE with result and flags written at the accept edge.
- Shifts go to SHIFT with the working register loaded from a and the counter loaded from shamt. Each cycle:
  - shift or rotate by 1;
  - record the bit shifted out;
  - decrement the counter.
  When the counter reaches 0, the block writes result and flags and goes to DONE. shamt=0 goes directly to DONE with result=a and C=0.
- DONE: out_valid=1, and result and flags are held stable. On out_ready the block goes to IDLE, or accepts a new op in the same cycle when in_valid is high.
- Flag rules. Only the listed flags update; all others hold.
  - ADD: C = carry out. V = signed overflow. Z, N, S update.
  - SUB: a-b. C = borrow (a<b unsigned). V, Z, N, S update.
  - CMP: same flags as SUB, plus EQ=(a==b). result is not updated.
  - AND, OR, XOR, PASS: C=0, V=0. Z, N, S update.
  - Shifts: C = last bit shifted out. V=0. Z, N, S update. SRA replicates the MSB.
  - ILL is written on every result: 1 for an illegal op, otherwise 0. An illegal op sets result=0 and leaves the other flags unchanged.
- Arithmetic is modulo 2^WIDTH.

## Timing

- Reset values: result=0, flags=0, out_valid=0, busy=0, state=IDLE; in_ready=1 once reset is released.
- Asserting rst_n mid-operation aborts the op. No out_valid is produced for it.
- Latency from the accept edge to out_valid:
  - single-cycle ops: 1 cycle;
  - shifts: 1+shamt cycles;
  - MUL: WIDTH+1 cycles.
- Back-to-back single-cycle ops with out_ready held high sustain one op per cycle.
- out_valid never drops without out_ready.

## Configuration

- ALU_MUL_EN defined: op 12 is an unsigned iterative shift-add multiply, one bit of b per cycle in state MUL.
  - result = low WIDTH bits of the product.
  - C=V=1 if the high half is nonzero.
  - Z, N, S come from the low half.
- ALU_MUL_EN undefined: the MUL state and its datapath are absent, and op 12 is illegal.

## Structure

- Package alu_seq_pkg holds:
  - the opcode enum;
  - flag bit index constants;
  - the state enum.
- Sub-module alu_core: the combinational single-cycle datapath. Inputs: op, a, b, current flags. Outputs: next result and next flags.
- The FSM, shift counter, working register and MUL accumulator live in alu_seq.

## Test plan

All scenarios use WIDTH=8.

- ADD a=0x7F b=0x01 -> result 0x80 one cycle later; C=0, Z=0, N=1, V=1, S=0.
- SUB a=0x00 b=0x01 -> 0xFF, C=1, N=1. Then CMP a=0x55 b=0x55 -> EQ=1, Z=1, result stays 0xFF.
- SRA a=0x81 shamt=1 -> 0xC0, C=1, out_valid 2 cycles after accept. ROR a=0x01 shamt=3 -> 0x20, C=0, 4-cycle latency, busy high for 3 cycles.
- Hold out_ready low 5 cycles after an ADD -> result, flags and out_valid stable, in_ready=0. Raising out_ready with in_valid high accepts the next op in that same cycle.
- SLL a=0x01 shamt=7, drop rst_n after 3 cycles -> result=0, flags=0, out_valid=0 immediately; in_ready=1 after release; no stale out_valid.
- MUL a=0x10 b=0x10: with ALU_MUL_EN -> result 0x00, C=V=Z=1 after 9 cycles. Without it -> ILL=1, result 0, 1 cycle.
